// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: operation codes,
// sequencer state encoding and the JK next-state rule.
package jk_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   // Next Q of a JK flip-flop given its present Q and the {J,K} drive.
   function automatic logic jk_next(input logic q, input logic [1:0] jk);
      logic q_n;
      case (jk)
         OP_HOLD: q_n = q;
         OP_RST:  q_n = 1'b0;
         OP_SET:  q_n = 1'b1;
         default: q_n = ~q;
      endcase
      return q_n;
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Show-ahead command FIFO: the head entry is visible on rdata while the
// FIFO is non-empty so the sequencer can load it on the same edge it pops.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level_reg == FULL_LVL);
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign rdata   = mem[rd_ptr_reg];
   // A full FIFO refuses a push even when a pop frees a slot this cycle.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + LVL_ONE;
            2'b01:   level_reg <= level_reg - LVL_ONE;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_seq.sv
// Command sequencer for a JK flip-flop: queues operations, replays each one
// for rpt+1 cycles and checks the flip-flop's Q against a shadow model.
module jk_cmd_seq
   import jk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [CNT_W-1:0]       cmd_rpt,
   output logic                   din_j,
   output logic                   din_k,
   input  logic                   dout_q,
   output logic                   exp_q,
   output logic                   mismatch,
   input  logic                   clr_mismatch,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level
);

   localparam int CW = 2 + CNT_W;
   localparam logic [CNT_W-1:0] RPT_ONE = CNT_W'(1);

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CW-1:0]    fifo_wdata;
   logic [CW-1:0]    fifo_rdata;
   logic [1:0]       head_op;
   logic [CNT_W-1:0] head_rpt;

   state_t           state_reg, state_next;
   logic [1:0]       op_reg, op_next;
   logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
   logic             exp_q_reg, exp_q_next;
   logic             mismatch_reg, mismatch_next;

   assign fifo_push  = cmd_valid & ~fifo_full;
   assign fifo_wdata = {cmd_op, cmd_rpt};
   assign head_op    = fifo_rdata[CW-1 -: 2];
   assign head_rpt   = fifo_rdata[CNT_W-1:0];

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CW)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // op_reg is the J/K drive register itself; it holds HOLD whenever idle.
   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      rpt_cnt_next = rpt_cnt_reg;
      fifo_pop     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               op_next      = head_op;
               rpt_cnt_next = head_rpt;
               state_next   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rpt_cnt_reg != '0) begin
               rpt_cnt_next = rpt_cnt_reg - RPT_ONE;
            end else if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               op_next      = head_op;
               rpt_cnt_next = head_rpt;
            end else begin
               op_next    = OP_HOLD;
               state_next = ST_IDLE;
            end
         end
         default: begin
            op_next    = OP_HOLD;
            state_next = ST_IDLE;
         end
      endcase
   end

   // The shadow Q follows the drive already on the wires, edge for edge
   // with the flip-flop; a divergence latches until explicitly cleared.
   always_comb begin
      exp_q_next    = jk_next(exp_q_reg, op_reg);
      mismatch_next = mismatch_reg;
      if (exp_q_reg != dout_q) begin
         mismatch_next = 1'b1;
      end else if (clr_mismatch) begin
         mismatch_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg    <= ST_IDLE;
         op_reg       <= OP_HOLD;
         rpt_cnt_reg  <= '0;
         exp_q_reg    <= 1'b0;
         mismatch_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         op_reg       <= op_next;
         rpt_cnt_reg  <= rpt_cnt_next;
         exp_q_reg    <= exp_q_next;
         mismatch_reg <= mismatch_next;
      end
   end

   assign cmd_ready = ~fifo_full;
   assign din_j     = op_reg[1];
   assign din_k     = op_reg[0];
   assign exp_q     = exp_q_reg;
   assign mismatch  = mismatch_reg;
   assign busy      = (state_reg == ST_ISSUE);

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_jk_cmd_seq;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk;
   logic             n_rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_rpt;
   logic             din_j;
   logic             din_k;
   logic             dout_q;
   logic             exp_q;
   logic             mismatch;
   logic             clr_mismatch;
   logic             busy;
   logic [LW-1:0]    level;

   int total;
   int bad;
   int cyc;

   typedef struct {
      logic [1:0] op;
      int         rpt;
   } cmd_t;

   cmd_t       m_fifo[$];
   logic [1:0] m_drv;
   int         m_left;
   logic       m_exp;
   logic       m_mis;
   logic       m_acc;
   logic       ff_q;
   logic       tie_en;
   logic       tie_val;

   jk_cmd_seq #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_rpt      (cmd_rpt),
      .din_j        (din_j),
      .din_k        (din_k),
      .dout_q       (dout_q),
      .exp_q        (exp_q),
      .mismatch     (mismatch),
      .clr_mismatch (clr_mismatch),
      .busy         (busy),
      .level        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic jk(input logic q, input logic [1:0] drv);
      case (drv)
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~q;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic check();
      cmp("cmd_ready", 32'(cmd_ready), 32'(m_fifo.size() < DEPTH));
      cmp("din_jk",    32'({din_j, din_k}), 32'(m_drv));
      cmp("exp_q",     32'(exp_q), 32'(m_exp));
      cmp("mismatch",  32'(mismatch), 32'(m_mis));
      cmp("busy",      32'(busy), 32'(m_left > 0));
      cmp("level",     32'(level), 32'(m_fifo.size()));
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_drv  = 2'b00;
      m_left = 0;
      m_exp  = 1'b0;
      m_mis  = 1'b0;
      m_acc  = 1'b0;
      ff_q   = 1'b0;
   endtask

   // One clock edge of the sequencer as seen from outside: the shadow Q
   // applies the drive present before the edge, a finished command hands
   // over to the queue head, and a push lands behind everything queued.
   task automatic model_edge();
      logic ready;
      logic old_exp;
      cmd_t c;
      old_exp = m_exp;
      ready   = (m_fifo.size() < DEPTH);
      m_exp   = jk(m_exp, m_drv);
      if (old_exp != dout_q) m_mis = 1'b1;
      else if (clr_mismatch) m_mis = 1'b0;
      if (m_left > 1) begin
         m_left--;
      end else if (m_fifo.size() > 0) begin
         c      = m_fifo.pop_front();
         m_drv  = c.op;
         m_left = c.rpt + 1;
      end else begin
         m_drv  = 2'b00;
         m_left = 0;
      end
      m_acc = cmd_valid && ready;
      if (m_acc) begin
         c.op  = cmd_op;
         c.rpt = int'(cmd_rpt);
         m_fifo.push_back(c);
         $display("push op=%0d rpt=%0d cycle=%0d level=%0d", cmd_op, cmd_rpt, cyc, m_fifo.size());
      end
   endtask

   // Called at a falling edge; advances one rising edge and checks at the next fall.
   task automatic step();
      logic [1:0] dq;
      dq = {din_j, din_k};
      @(posedge clk);
      #1;
      cyc++;
      if (n_rst) begin
         model_edge();
         ff_q = jk(ff_q, dq);
      end else begin
         m_acc = 1'b0;
      end
      dout_q = tie_en ? tie_val : ff_q;
      @(negedge clk);
      check();
   endtask

   task automatic do_reset();
      #2;
      n_rst        = 1'b0;
      cmd_valid    = 1'b0;
      clr_mismatch = 1'b0;
      model_reset();
      dout_q = tie_en ? tie_val : ff_q;
      #1;
      check();
      cmp("rst_din",   32'({din_j, din_k}), 32'd0);
      cmp("rst_exp",   32'(exp_q), 32'd0);
      cmp("rst_level", 32'(level), 32'd0);
      cmp("rst_busy",  32'(busy), 32'd0);
      cmp("rst_ready", 32'(cmd_ready), 32'd1);
      cmp("rst_mis",   32'(mismatch), 32'd0);
      step();
      step();
      n_rst = 1'b1;
   endtask

   task automatic push_hold(input logic [1:0] op, input int rpt, output int acc_cyc);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_rpt   = CNT_W'(rpt);
      m_acc     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (m_acc) break;
      end
      if (!m_acc) begin
         total++;
         bad++;
         $display("FAIL push_timeout: got no accept expected accept op=%0d rpt=%0d", op, rpt);
      end
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (m_left == 0 && m_fifo.size() == 0) break;
         step();
      end
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   a;
      int   base;
      logic tgl_seq [4];
      logic [1:0] ops [6];
      tgl_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
      ops     = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
      total = 0;
      bad   = 0;
      cyc   = 0;
      n_rst        = 1'b0;
      cmd_valid    = 1'b0;
      cmd_op       = 2'b00;
      cmd_rpt      = '0;
      clr_mismatch = 1'b0;
      tie_en       = 1'b0;
      tie_val      = 1'b0;
      dout_q       = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check();
      cmp("init_ready", 32'(cmd_ready), 32'd1);
      cmp("init_din",   32'({din_j, din_k}), 32'd0);
      cmp("init_level", 32'(level), 32'd0);
      n_rst = 1'b1;
      step();

      // Single SET rpt=0
      push_hold(2'b10, 0, a);
      step();
      cmp("set_din_e2",  32'({din_j, din_k}), 32'b10);
      cmp("set_busy_e2", 32'(busy), 32'd1);
      step();
      cmp("set_din_e3",  32'({din_j, din_k}), 32'b00);
      cmp("set_exp_e3",  32'(exp_q), 32'd1);
      step();
      cmp("set_exp_e4",  32'(exp_q), 32'd1);
      cmp("set_busy_e4", 32'(busy), 32'd0);

      // TOGGLE rpt=3 from Q=0
      do_reset();
      push_hold(2'b11, 3, a);
      step();
      cmp("tgl_din", 32'({din_j, din_k}), 32'b11);
      for (int k = 0; k < 4; k++) begin
         step();
         cmp("tgl_exp", 32'(exp_q), 32'(tgl_seq[k]));
      end
      cmp("tgl_mis", 32'(mismatch), 32'd0);
      drain();

      // Back-to-back SET / RESET / TOGGLE rpt1
      do_reset();
      push_hold(2'b10, 0, a);
      push_hold(2'b01, 0, a);
      cmp("b2b_e2", 32'({din_j, din_k}), 32'b10);
      push_hold(2'b11, 1, a);
      cmp("b2b_e3", 32'({din_j, din_k}), 32'b01);
      step();
      cmp("b2b_e4", 32'({din_j, din_k}), 32'b11);
      step();
      cmp("b2b_e5", 32'({din_j, din_k}), 32'b11);
      cmp("b2b_busy_e5", 32'(busy), 32'd1);
      step();
      cmp("b2b_e6", 32'({din_j, din_k}), 32'b00);
      cmp("b2b_busy_e6", 32'(busy), 32'd0);
      cmp("b2b_exp", 32'(exp_q), 32'd0);

      // Full FIFO / backpressure
      do_reset();
      base = cyc;
      for (int k = 0; k < 5; k++) push_hold(ops[k], 15, a);
      cmp("full_level", 32'(level), 32'd4);
      cmp("full_ready", 32'(cmd_ready), 32'd0);
      push_hold(ops[5], 15, a);
      cmp("full_cmd6_edge", 32'(a - base), 32'd19);
      drain();

      // Mismatch with Q tied low
      tie_en  = 1'b1;
      tie_val = 1'b0;
      do_reset();
      push_hold(2'b10, 0, a);
      step();
      step();
      cmp("mis_exp_e3", 32'(exp_q), 32'd1);
      cmp("mis_e3",     32'(mismatch), 32'd0);
      step();
      cmp("mis_e4",     32'(mismatch), 32'd1);
      clr_mismatch = 1'b1;
      push_hold(2'b01, 0, a);
      cmp("mis_clr_held", 32'(mismatch), 32'd1);
      step();
      step();
      cmp("mis_exp_e7", 32'(exp_q), 32'd0);
      cmp("mis_e7",     32'(mismatch), 32'd1);
      step();
      cmp("mis_cleared", 32'(mismatch), 32'd0);
      clr_mismatch = 1'b0;
      tie_en       = 1'b0;

      // Reset on the 3rd issue cycle of TOGGLE rpt=7 with a command queued
      do_reset();
      push_hold(2'b11, 7, a);
      push_hold(2'b10, 3, a);
      step();
      step();
      cmp("mid_busy", 32'(busy), 32'd1);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step();
         cmp("post_rst_din", 32'({din_j, din_k}), 32'd0);
      end

      // Random traffic
      m_acc = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!cmd_valid || m_acc) begin
            cmd_valid = ($urandom_range(2) != 0);
            cmd_op    = 2'($urandom_range(3));
            cmd_rpt   = ($urandom_range(5) == 0) ? CNT_W'($urandom_range(15))
                                                 : CNT_W'($urandom_range(2));
         end
         clr_mismatch = ($urandom_range(3) == 0);
         tie_en       = ($urandom_range(9) == 0);
         tie_val      = 1'($urandom_range(1));
         if (i == 200) do_reset();
         step();
      end
      cmd_valid    = 1'b0;
      clr_mismatch = 1'b0;
      tie_en       = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
